// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// State encoding plus chunk-count / index-width calculations.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index register needs at least one bit even when there is a single chunk.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder with carry in and carry out.
// The single shared arithmetic element reused on every iteration.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_seq_ctrl.sv
// WIDTH-bit add computed over NCHUNK cycles with one CHUNK-bit adder, LSB chunk first.
// Define ADDER_SEQ_SUB_EN to add the 'sub' port (a - b - cin, cout = borrow).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high; ready never depends on valid. start_ready is high only in IDLE, res_valid is
// high only in DONE, and res_valid stays high with sum/cout stable until res_ready.
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output state_t           state_dbg
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_w(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_s;
    logic              chunk_co;
    logic              final_co;
`ifdef ADDER_SEQ_SUB_EN
    logic              sub_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)         state_d = RUN;
            RUN:     if (idx_q == LAST_IDX)   state_d = DONE;
            DONE:    if (res_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    adder_chunk #(.W(CHUNK)) u_chunk (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Subtraction runs as a + ~b + ~cin; inverting the carry out turns it into a borrow.
`ifdef ADDER_SEQ_SUB_EN
    assign final_co = chunk_co ^ sub_q;
`else
    assign final_co = chunk_co;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= a;
                        idx_q <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
`ifdef ADDER_SEQ_SUB_EN
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? ~cin : cin;
                        sub_q   <= sub;
`else
                        b_q     <= b;
                        carry_q <= cin;
`endif
                    end
                end
                RUN: begin
                    sum[idx_q*CHUNK +: CHUNK] <= chunk_s;
                    carry_q <= chunk_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout <= final_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a CHUNK=8 instance (four iterations) and a CHUNK=32 instance
// (one iteration), both checked against an arithmetic reference model.
module tb_adder_seq_ctrl;
    import adder_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_valid_s [2];
    logic        start_ready_s [2];
    logic [31:0] a_s           [2];
    logic [31:0] b_s           [2];
    logic        cin_s         [2];
    logic        res_valid_s   [2];
    logic        res_ready_s   [2];
    logic [31:0] sum_s         [2];
    logic        cout_s        [2];
    logic        busy_s        [2];
    state_t      st_s          [2];
`ifdef ADDER_SEQ_SUB_EN
    logic        sub_s         [2];
`endif

    int vectors;
    int miscompares;
    logic [32:0] exp_q[$];

    adder_seq_ctrl #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid_s[0]), .start_ready(start_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]),
`ifdef ADDER_SEQ_SUB_EN
        .sub(sub_s[0]),
`endif
        .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0]),
        .sum(sum_s[0]), .cout(cout_s[0]), .busy(busy_s[0]), .state_dbg(st_s[0])
    );

    adder_seq_ctrl #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid_s[1]), .start_ready(start_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]),
`ifdef ADDER_SEQ_SUB_EN
        .sub(sub_s[1]),
`endif
        .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1]),
        .sum(sum_s[1]), .cout(cout_s[1]), .busy(busy_s[1]), .state_dbg(st_s[1])
    );

    // Clock and time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain unsigned arithmetic on the full width.
    function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv, input logic sv);
        logic [32:0] r;
        if (sv) begin
            r[31:0] = av - bv - 32'(cv);
            r[32]   = ({1'b0, av} < ({1'b0, bv} + 33'(cv)));
        end else begin
            r = {1'b0, av} + {1'b0, bv} + 33'(cv);
        end
        return r;
    endfunction

    function automatic int nchunk(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk_bit(input string tag, input int d, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed=%b expected=%b", tag, d, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int d, input logic [32:0] obs, input logic [32:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int d, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed=%0d expected=%0d", tag, d, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_sub(input int d, input logic sv);
`ifdef ADDER_SEQ_SUB_EN
        sub_s[d] = sv;
`else
        if (sv) $display("note: sub ignored in add-only build (dut%0d)", d);
`endif
    endtask

    task automatic check_idle(input string tag, input int d);
        chk_bit({tag, "_start_ready"}, d, start_ready_s[d], 1'b1);
        chk_bit({tag, "_res_valid"},   d, res_valid_s[d],   1'b0);
        chk_bit({tag, "_busy"},        d, busy_s[d],        1'b0);
    endtask

    // One command: accept, garbage inputs during RUN, check latency/result, hold, consume.
    task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic sv, input int hold);
        logic [32:0] exp;
        int cyc;
        a_s[d] = av; b_s[d] = bv; cin_s[d] = cv; drive_sub(d, sv);
        start_valid_s[d] = 1'b1;
        res_ready_s[d]   = 1'b0;
        chk_bit("accept_ready", d, start_ready_s[d], 1'b1);
        exp_q.push_back(model(av, bv, cv, sv));
        tick();
        cyc = 0;
        while (!res_valid_s[d] && cyc < 40) begin
            chk_bit("run_busy", d, busy_s[d], 1'b1);
            chk_bit("run_start_ready", d, start_ready_s[d], 1'b0);
            a_s[d] = $urandom; b_s[d] = $urandom; cin_s[d] = 1'($urandom);
            drive_sub(d, 1'($urandom));
            start_valid_s[d] = 1'($urandom);
            res_ready_s[d]   = 1'($urandom);
            tick();
            cyc++;
        end
        chk_int("latency", d, cyc, nchunk(d));
        start_valid_s[d] = 1'b0;
        res_ready_s[d]   = 1'b0;
        exp = exp_q.pop_front();
        chk_res("result", d, {cout_s[d], sum_s[d]}, exp);
        chk_bit("done_busy", d, busy_s[d], 1'b1);
        for (int i = 0; i < hold; i++) begin
            start_valid_s[d] = 1'b1;
            a_s[d] = $urandom; b_s[d] = $urandom;
            tick();
            chk_bit("hold_valid", d, res_valid_s[d], 1'b1);
            chk_bit("hold_start_ready", d, start_ready_s[d], 1'b0);
            chk_res("hold_result", d, {cout_s[d], sum_s[d]}, exp);
        end
        start_valid_s[d] = 1'b0;
        res_ready_s[d]   = 1'b1;
        tick();
        res_ready_s[d] = 1'b0;
        check_idle("consumed", d);
    endtask

    // Both sides always ready: three commands, checking order, latency and spacing.
    task automatic stream(input int d);
        int cyc, accepts, results, last_res;
        int acc_q[$];
        logic [32:0] exp;
        int acc;
        logic sv;
        cyc = 0; accepts = 0; results = 0; last_res = 0;
        start_valid_s[d] = 1'b1;
        res_ready_s[d]   = 1'b1;
        while (results < 3 && cyc < 200) begin
            if (res_valid_s[d]) begin
                exp = exp_q.pop_front();
                acc = acc_q.pop_front();
                chk_res("stream_result", d, {cout_s[d], sum_s[d]}, exp);
                chk_int("stream_latency", d, cyc - acc - 1, nchunk(d));
                if (results > 0) chk_int("stream_period", d, cyc - last_res, nchunk(d) + 2);
                last_res = cyc;
                results++;
            end
            if (start_ready_s[d] && accepts < 3) begin
                a_s[d] = $urandom; b_s[d] = $urandom; cin_s[d] = 1'($urandom);
`ifdef ADDER_SEQ_SUB_EN
                sv = 1'($urandom);
`else
                sv = 1'b0;
`endif
                drive_sub(d, sv);
                exp_q.push_back(model(a_s[d], b_s[d], cin_s[d], sv));
                acc_q.push_back(cyc);
                accepts++;
            end else if (accepts >= 3) begin
                start_valid_s[d] = 1'b0;
            end
            tick();
            cyc++;
        end
        chk_int("stream_count", d, results, 3);
        start_valid_s[d] = 1'b0;
        res_ready_s[d]   = 1'b0;
        exp_q.delete();
        tick();
        check_idle("stream_end", d);
    endtask

    initial begin
        logic sv;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_valid_s[d] = 1'b0; res_ready_s[d] = 1'b0;
            a_s[d] = '0; b_s[d] = '0; cin_s[d] = 1'b0;
            drive_sub(d, 1'b0);
        end

        // Reset values.
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle("reset", d);
            chk_res("reset_result", d, {cout_s[d], sum_s[d]}, 33'd0);
            chk_bit("reset_state_idle", d, st_s[d] == IDLE, 1'b1);
        end
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 0);

        // Directed: full carry ripple, then carry-in with no final carry.
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        chk_res("ripple_const", 0, {cout_s[0], sum_s[0]}, 33'h1_0000_0000);
        do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);
        chk_res("cin_const", 0, {cout_s[0], sum_s[0]}, 33'h0_2345_678A);

        // Result held back for five cycles while new commands are offered.
        do_op(0, 32'hDEAD_BEEF, 32'h8000_0001, 1'b1, 1'b0, 5);
        do_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);

        // Reset two cycles into RUN aborts the operation.
        a_s[0] = 32'hAAAA_5555; b_s[0] = 32'h1234_4321; cin_s[0] = 1'b1;
        start_valid_s[0] = 1'b1;
        tick();
        start_valid_s[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle("abort", 0);
        chk_res("abort_result", 0, {cout_s[0], sum_s[0]}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0);
        chk_res("after_abort_const", 0, {cout_s[0], sum_s[0]}, 33'd7);

        // Single-chunk instance: directed and boundary values.
        do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        do_op(1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);

`ifdef ADDER_SEQ_SUB_EN
        do_op(0, 32'd5, 32'd7, 1'b0, 1'b1, 0);
        chk_res("sub_borrow_const", 0, {cout_s[0], sum_s[0]}, 33'h1_FFFF_FFFE);
        do_op(0, 32'd7, 32'd5, 1'b0, 1'b1, 0);
        chk_res("sub_plain_const", 0, {cout_s[0], sum_s[0]}, 33'h0_0000_0002);
        do_op(1, 32'd0, 32'd0, 1'b1, 1'b1, 1);
`endif

        // Randomized commands on both instances.
        for (int i = 0; i < 24; i++) begin
`ifdef ADDER_SEQ_SUB_EN
            sv = 1'($urandom);
`else
            sv = 1'b0;
`endif
            do_op(i % 2, $urandom, $urandom, 1'($urandom), sv, $urandom_range(0, 3));
        end

        // Back-to-back streaming on both instances.
        stream(0);
        stream(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that computes a WIDTH-bit add using one CHUNK-bit adder, iterating over operand chunks, least significant first.
A carry register links the iterations.
Valid/ready handshakes on the command and result sides.
Catalog element for building wide arithmetic from a narrow shared adder.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of CHUNK.
CHUNK, 8, width of the internal adder; NCHUNK = WIDTH/CHUNK, NCHUNK >= 1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_valid  in  1  command valid.
start_ready  out  1  command accepted when high with start_valid.
a  in  WIDTH  operand A, sampled at accept only.
b  in  WIDTH  operand B, sampled at accept only.
cin  in  1  carry-in, sampled at accept only.
res_valid  out  1  result valid.
res_ready  in  1  result consumer ready.
sum  out  WIDTH  result register.
cout  out  1  final carry-out.
busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values:
  - State is IDLE; chunk index and carry are 0.
  - sum=0, cout=0, res_valid=0, busy=0.
  - start_ready=1, because it is decoded from IDLE.
- FSM states: IDLE, RUN, DONE.
- Outputs decoded from state:
  - start_ready = (state==IDLE).
  - res_valid = (state==DONE).
  - busy = !IDLE.
- IDLE:
  - On start_valid && start_ready, latch a and b.
  - Load carry <= cin and idx <= 0.
  - Clear sum to 0 and cout to 0.
  - Go to RUN.
- RUN, every cycle:
  - The chunk adder computes a[idx] + b[idx] + carry.
  - Write the result into sum[idx*CHUNK +: CHUNK]; carry <= chunk carry-out; idx <= idx+1.
  - When idx==NCHUNK-1, write cout from the chunk carry-out and go to DONE.
- DONE:
  - Hold sum and cout stable.
  - On res_ready, go to IDLE. The result is consumed in the same cycle.
- Latency: res_valid rises exactly NCHUNK cycles after the accept edge.
- Throughput: one command per NCHUNK+2 cycles with both sides always ready. There is no overlap between commands.
- start_valid is ignored while not in IDLE. Changes on a, b or cin after accept have no effect.
- NCHUNK==1: RUN lasts one cycle. Result follows 1 cycle after accept.
- res_ready asserted outside DONE has no effect.
- Reset asserted mid-RUN or mid-DONE:
  - Aborts the operation immediately; all reset values apply.
  - No partial result is ever flagged valid.
- sum is the working register. It is meaningful only while res_valid=1; during RUN the upper chunks read 0.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.

Optional Feature:
Macro: ADDER_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled at accept.
  - With sub=1, B is latched as ~b, the initial carry is ~cin, and the final cout is stored inverted.
  - Result: sum = a - b - cin mod 2^WIDTH, and cout=1 means a borrow occurred.
  - With sub=0, behaviour is identical to add.
- Undefined: no sub port; add only; no extra logic.

Decomposition:
- Package adder_pkg:
  - State enum typedef (IDLE/RUN/DONE).
  - Localparam helper for NCHUNK, and the index width $clog2(NCHUNK) (min 1).
- Sub-module adder_chunk:
  - Combinational CHUNK-bit adder with ports a, b, ci, s, co.
  - One instance in adder_seq_ctrl.

Test Plan (WIDTH=32, CHUNK=8 unless noted):
1. a=32'hFFFF_FFFF, b=1, cin=0 -> res_valid 4 cycles after accept, sum=0, cout=1.
2. a=32'h1234_5678, b=32'h1111_1111, cin=1 -> sum=32'h2345_678A, cout=0; start_ready=0 for the whole operation.
3. Hold res_ready=0 for 5 cycles in DONE and pulse start_valid with new operands -> res_valid stays 1, sum/cout stable, no command accepted; after res_ready=1 the next command is accepted in IDLE.
4. Assert rst_n=0 two cycles into RUN -> res_valid=0, busy=0, sum=0 immediately. A following command a=3, b=4 gives sum=7, cout=0.
5. start_valid=1 and res_ready=1 continuously with 3 distinct operand sets -> results in order, one every 6 cycles. Repeat with CHUNK=32 -> one every 3 cycles, latency 1.
6. With ADDER_SEQ_SUB_EN: a=5, b=7, cin=0, sub=1 -> sum=32'hFFFF_FFFE, cout=1. Then a=7, b=5, sub=1 -> sum=2, cout=0.
